pulse_arbiter: RTL

Shares one timed pulse generator between N_REQ active-low button-style requesters. Each requester input is synchronised and glitch-filtered, and each press latches one pending request. A round-robin scheduler grants pending requests one at a time. Each grant produces exactly one pulse of PULSE_US, followed by a GAP_US quiet gap. The block sits between the front-panel push inputs and the single pulse output line.

---
 rtl/pulse_arb_pkg.sv | 20 ++
 rtl/pulse_arbiter_if.sv | 39 +++
 rtl/req_filter.sv | 62 ++++++
 rtl/pulse_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// pulse_arb_pkg: shared types and helpers for the pulse arbiter.
//   state_t     - arbiter FSM states
//   SYNC_STAGES - depth of the per-requester input synchroniser
//   us_to_cyc   - converts a microsecond duration into clk cycles (64-bit)
package pulse_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Truncating conversion; the caller clamps to any minimum it needs.
  function automatic logic [63:0] us_to_cyc(input logic [63:0] clk_hz, input logic [63:0] us);
    return (clk_hz * us) / 64'd1_000_000;
  endfunction

endpackage

// File: rtl/pulse_arbiter_if.sv
// pulse_arbiter_if: request and pulse-output bundle of the pulse arbiter.
//   req_n     - active-low requests (asynchronous to clk)
//   pulse_out - shared timed pulse
//   grant_id  - index of the current or last granted requester
//   busy      - arbiter is serving a pulse or its quiet gap
//   pend      - pending-request flags
//   drop      - one-cycle strobe when a press coalesces into a set pend bit
// Modports: master drives the requests (front panel side), slave is the arbiter.
interface pulse_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req_n;
  logic             pulse_out;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] drop;

  modport master (
    output req_n,
    input  pulse_out,
    input  grant_id,
    input  busy,
    input  pend,
    input  drop
  );

  modport slave (
    input  req_n,
    output pulse_out,
    output grant_id,
    output busy,
    output pend,
    output drop
  );

endinterface

// File: rtl/req_filter.sv
// req_filter: front end for one active-low push input.
//   clk, rst - system clock, asynchronous active-high reset
//   req_n    - raw active-low request, asynchronous to clk
//   accept   - one-cycle strobe when a press is accepted
// The input is synchronised, then must stay low for FILT_CYC synchronised
// cycles. A release re-arms the filter, so a held button yields one accept.
module req_filter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_n,
  output logic accept
);

  localparam int unsigned CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] valid_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   arm_q, arm_d;
  logic                   s;
  logic                   s_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      valid_q <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], req_n};
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  // The reset value of the synchroniser is not a real observation of the pin;
  // ignoring it keeps a button held through reset from arming the filter.
  assign s_valid = valid_q[SYNC_STAGES-1];

  assign accept = arm_q && (cnt_q == FILT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    arm_d = accept ? 1'b0 : arm_q;
    if (!s_valid) begin
      cnt_d = '0;
    end else if (s) begin
      cnt_d = '0;
      arm_d = 1'b1;
    end else if (cnt_q != FILT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/pulse_arbiter.sv
// pulse_arbiter: shares one timed pulse generator between N_REQ push inputs.
//   clk, rst - system clock, asynchronous active-high reset
//   bus      - slave side of pulse_arbiter_if (req_n in; pulse_out, grant_id,
//              busy, pend, drop out)
// Each accepted press latches a pend bit; a round-robin scheduler serves pend
// bits one at a time with a PULSE_US high pulse followed by a GAP_US quiet gap.
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CLK_HZ   = 5_000_000,
  parameter int unsigned PULSE_US = 100,
  parameter int unsigned GAP_US   = 10,
  parameter int unsigned FILT_CYC = 4
) (
  input logic            clk,
  input logic            rst,
  pulse_arbiter_if.slave bus
);

  localparam logic [63:0] PULSE_RAW = us_to_cyc(64'(CLK_HZ), 64'(PULSE_US));
  localparam logic [63:0] PULSE_CYC = (PULSE_RAW == 64'd0) ? 64'd1 : PULSE_RAW;
  localparam logic [63:0] GAP_CYC   = us_to_cyc(64'(CLK_HZ), 64'(GAP_US));
  localparam logic [63:0] CNT_MAX   = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 64'd1);
  localparam int unsigned ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 64'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYC == 64'd0) ? '0 : CNT_W'(GAP_CYC - 64'd1);

  if (PULSE_CYC > 64'hFFFF_FFFF) begin : g_pulse_range
    $fatal(1, "pulse_arbiter: pulse length exceeds 2^32-1 cycles");
  end
  if (GAP_CYC > 64'hFFFF_FFFF) begin : g_gap_range
    $fatal(1, "pulse_arbiter: gap length exceeds 2^32-1 cycles");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : g_nreq_range
    $fatal(1, "pulse_arbiter: N_REQ must be in 2..16");
  end

  // First set bit strictly after 'last', wrapping around. Iterating from the
  // farthest offset down lets the nearest candidate overwrite the others.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      idx = (int'(last) + off) % int'(N_REQ);
      if (req[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  logic [N_REQ-1:0] accept;

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_filt
    req_filter #(
      .FILT_CYC(FILT_CYC)
    ) u_filt (
      .clk   (clk),
      .rst   (rst),
      .req_n (bus.req_n[i]),
      .accept(accept[i])
    );
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [N_REQ-1:0] clr;
  logic [ID_W-1:0]  pick;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    clr     = '0;
    pick    = rr_pick(pend_q, last_q);

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          clr[pick] = 1'b1;
          grant_d   = pick;
          last_d    = pick;
          cnt_d     = PULSE_LOAD;
          state_d   = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (GAP_CYC != 64'd0) begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh acceptance wins over the grant clearing the same bit.
    pend_d = (pend_q & ~clr) | accept;
    drop_d = accept & pend_q & ~clr;
  end

  // Outputs.
  always_comb begin
    bus.pulse_out = (state_q == PULSE);
    bus.busy      = (state_q != IDLE);
    bus.grant_id  = grant_q;
    bus.pend      = pend_q;
    bus.drop      = drop_q;
  end

endmodule
